imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Upstream feeder of the single-cycle MIPS-lite core.
- Receives a framed program image as a byte stream and writes it into the 32-byte instruction memory through a byte write port.
- Verifies an 8-bit checksum, then releases the core: one-cycle PC clear, then cpu_run held for a bounded number of cycles.
- Replaces file-based instruction memory preload and the fixed-time stop in hardware builds.

Parameters:
MEM_BYTES, 32, instruction memory size in bytes; power of two, multiple of 4
ADDR_W, 5, log2(MEM_BYTES)
RUN_CYCLES, 10, number of clock cycles cpu_run stays high before the loader stops the core

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERR
byte_in  in  8  stream data byte
byte_valid  in  1  byte_in valid
byte_ready  out  1  loader accepts a byte this cycle
mem_we  out  1  instruction memory byte write enable
mem_addr  out  ADDR_W  instruction memory byte address
mem_wdata  out  8  byte to write
pc_clear  out  1  one-cycle pulse forcing core pc to 0
cpu_run  out  1  core clock-enable
busy  out  1  high in LEN, DATA, CHK
done  out  1  high in DONE
error  out  1  high in ERR
err_code  out  2  01 bad length, 10 checksum mismatch, 00 otherwise

Behaviour:
- Transfer occurs only on a cycle with byte_valid && byte_ready.
- byte_ready is a combinational decode of state: high in LEN, DATA and CHK; low elsewhere.
- All other outputs are registered.
- Reset: state IDLE. mem_we, pc_clear, cpu_run, busy, done, error = 0. err_code = 00. mem_addr = 0. mem_wdata = 0. Byte counter, length register, checksum and run counter all = 0.
- States and transitions:
  - IDLE: start -> LEN.
  - LEN: accept length byte L.
    - L = 0, L > MEM_BYTES, or L[1:0] != 0 -> ERR with err_code 01.
    - Otherwise store L, clear counter and sum -> DATA.
  - DATA: each accepted byte is written to address = counter and added to sum (mod 256); counter increments.
    - The byte that makes counter == L -> CHK.
  - CHK: accept checksum byte C.
    - C == sum -> RUN.
    - Otherwise -> ERR with err_code 10.
  - RUN: the entry cycle asserts pc_clear for exactly that cycle with cpu_run low. cpu_run is high on the following RUN_CYCLES cycles, then -> DONE.
  - DONE, ERR: hold until start; start -> LEN and clears err_code.
- Write timing: mem_we/mem_addr/mem_wdata are registered one cycle after the accepting edge. mem_we is high for exactly one cycle per data byte. mem_addr/mem_wdata hold their last values when mem_we = 0.
- No wrap-around: the addresses written are 0..L-1; bytes L..MEM_BYTES-1 are untouched.
- Byte order in memory follows stream order, so byte k lands at address k (big-endian words, matching the core's fetch).
- start is ignored in LEN, DATA, CHK and RUN.
- byte_valid outside LEN/DATA/CHK is ignored; no byte is consumed.
- Stalls: byte_valid low mid-frame holds the state indefinitely, with no timeout.
- rst mid-load or mid-run returns to IDLE next edge and drops cpu_run. Memory bytes already written keep their values.
- Checksum covers data bytes only, not the length byte.
- The run counter width is sufficient for RUN_CYCLES. It saturates and never wraps.

Test Plan:
1. Load: start, then stream L=0x08, bytes 01..08, C=0x24 -> mem_we pulses 8 times at addresses 0..7 with data 01..08, one cycle after each acceptance. Then pc_clear for 1 cycle, cpu_run high exactly 10 cycles, done=1, error=0.
2. Bad length: stream L=0x06, then separately L=0x00, then L=0x24 -> each goes to ERR with err_code 01, no mem_we, byte_ready low afterwards.
3. Checksum mismatch: L=0x04, bytes AA BB CC DD, C=0x00 (correct 0x0E) -> four writes occur, then error=1, err_code=10, cpu_run never high. A following start with a correct frame reaches DONE and err_code=00.
4. Stalls: L=0x04 with byte_valid low for 5 cycles between every byte, plus start pulses mid-frame -> same writes as an unstalled run, start ignored, byte_ready stays high in DATA.
5. Reset mid-operation: assert rst after 2 data bytes, then again on the 4th cycle of RUN -> IDLE next edge, all outputs at reset values, cpu_run drops immediately.
6. Full memory: L=0x20 with bytes 00..1F and C=0xF0 -> 32 writes, last at address 0x1F with data 0x1F, no write to address 0 after the first, then RUN.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed program image (length, data, checksum) as a byte stream,
// writes it into instruction memory, then releases the core for a bounded number of cycles.
module imem_boot_loader #(
  parameter int unsigned MEM_BYTES  = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned RUN_CYCLES = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              pc_clear,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned RUN_W = (RUN_CYCLES < 1) ? 1 : $clog2(RUN_CYCLES + 1);

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_SUM  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CHK, S_RUN, S_DONE, S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [7:0]         sum_q, sum_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [7:0]         mem_wdata_q, mem_wdata_d;
  logic               pc_clear_q, pc_clear_d;
  logic               cpu_run_q, cpu_run_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [1:0]         err_code_q, err_code_d;

  logic               accept;
  logic               len_bad;
  logic [CNT_W-1:0]   cnt_inc;

  assign byte_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
  assign accept     = byte_valid && byte_ready;
  assign len_bad    = (byte_in == 8'd0) || ({1'b0, byte_in} > 9'(MEM_BYTES)) ||
                      (byte_in[1:0] != 2'b00);
  assign cnt_inc    = CNT_W'(cnt_q + CNT_W'(1));

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    sum_d       = sum_q;
    run_cnt_d   = run_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pc_clear_d  = 1'b0;
    cpu_run_d   = 1'b0;
    err_code_d  = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN;
      end
      S_LEN: begin
        if (accept) begin
          if (len_bad) begin
            state_d    = S_ERR;
            err_code_d = ERR_LEN;
          end else begin
            state_d = S_DATA;
            len_d   = CNT_W'(byte_in);
            cnt_d   = '0;
            sum_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[ADDR_W-1:0];
          mem_wdata_d = byte_in;
          sum_d       = 8'(sum_q + byte_in);
          cnt_d       = cnt_inc;
          if (cnt_inc == len_q) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (byte_in == sum_q) begin
            state_d    = S_RUN;
            pc_clear_d = 1'b1;
            run_cnt_d  = '0;
          end else begin
            state_d    = S_ERR;
            err_code_d = ERR_SUM;
          end
        end
      end
      S_RUN: begin
        // Counter stops at RUN_CYCLES, so it never wraps
        if (run_cnt_q == RUN_W'(RUN_CYCLES)) begin
          state_d = S_DONE;
        end else begin
          cpu_run_d = 1'b1;
          run_cnt_d = RUN_W'(run_cnt_q + RUN_W'(1));
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN;
          err_code_d = ERR_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CHK);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERR);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      sum_q       <= '0;
      run_cnt_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pc_clear_q  <= 1'b0;
      cpu_run_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      run_cnt_q   <= run_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pc_clear_q  <= pc_clear_d;
      cpu_run_q   <= cpu_run_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc_clear  = pc_clear_q;
  assign cpu_run   = cpu_run_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: framed loads, bad frames, stalls, resets, full memory.
module tb_imem_boot_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       pc_clear;
  logic       cpu_run;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int wr0_cnt = 0;
  logic [7:0] tbmem [32];

  imem_boot_loader #(.MEM_BYTES(32), .ADDR_W(5), .RUN_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pc_clear(pc_clear), .cpu_run(cpu_run), .busy(busy), .done(done), .error(error),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Memory image as seen through the write port
  always @(posedge clk) begin
    if (mem_we) begin
      tbmem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
      if (mem_addr == 5'd0) wr0_cnt <= wr0_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    byte_in = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_data(input string tag, input logic [7:0] b, input logic [4:0] a);
    send(b);
    chk({tag, "_we"}, 32'(mem_we), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_data"}, 32'(mem_wdata), 32'(b));
  endtask

  // Count cpu_run/pc_clear cycles until done, bounded
  task automatic run_to_done(input string tag);
    int runs = 0;
    int pcs = 0;
    bit got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cpu_run) runs++;
      if (pc_clear) pcs++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_run_cycles"}, 32'(runs), 32'd10);
    chk({tag, "_pc_extra"}, 32'(pcs), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_errcode"}, 32'(err_code), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_flags"}, {26'd0, pc_clear, cpu_run, busy, done, error, 1'b0}, 32'd0);
    chk({tag, "_errcode"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    int w;
    int cr;
    rst = 1'b1; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    tick(); tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // 1: nominal load of 8 bytes
    w = wr_cnt;
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready", 32'(byte_ready), 32'd1);
    send(8'h08);
    for (int k = 0; k < 8; k++) send_data("t1", 8'(k + 1), 5'(k));
    send(8'h24);
    chk("t1_pcclr", 32'(pc_clear), 32'd1);
    chk("t1_run_entry", 32'(cpu_run), 32'd0);
    chk("t1_busy_run", 32'(busy), 32'd0);
    run_to_done("t1");
    chk("t1_nwr", 32'(wr_cnt - w), 32'd8);
    chk("t1_mem7", 32'(tbmem[7]), 32'h08);

    // 2: bad lengths
    w = wr_cnt;
    pulse_start();
    chk("t2_clear_done", 32'(done), 32'd0);
    send(8'h06);
    chk("t2a_error", 32'(error), 32'd1);
    chk("t2a_code", 32'(err_code), 32'd1);
    chk("t2a_ready", 32'(byte_ready), 32'd0);
    pulse_start();
    chk("t2_clear_code", 32'(err_code), 32'd0);
    send(8'h00);
    chk("t2b_code", 32'(err_code), 32'd1);
    pulse_start();
    send(8'h24);
    chk("t2c_error", 32'(error), 32'd1);
    chk("t2c_code", 32'(err_code), 32'd1);
    byte_valid = 1'b1; tick(); byte_valid = 1'b0;
    chk("t2_ready_err", 32'(byte_ready), 32'd0);
    chk("t2_nwr", 32'(wr_cnt - w), 32'd0);

    // 3: checksum mismatch then recovery
    w = wr_cnt;
    pulse_start();
    send(8'h04);
    send_data("t3", 8'hAA, 5'd0);
    send_data("t3", 8'hBB, 5'd1);
    send_data("t3", 8'hCC, 5'd2);
    send_data("t3", 8'hDD, 5'd3);
    send(8'h00);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_code", 32'(err_code), 32'd2);
    cr = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cpu_run || pc_clear) cr++;
    end
    chk("t3_no_run", 32'(cr), 32'd0);
    chk("t3_nwr", 32'(wr_cnt - w), 32'd4);
    chk("t3_mem4_untouched", 32'(tbmem[4]), 32'h05);
    pulse_start();
    send(8'h04);
    send_data("t3r", 8'h11, 5'd0);
    send_data("t3r", 8'h22, 5'd1);
    send_data("t3r", 8'h33, 5'd2);
    send_data("t3r", 8'h44, 5'd3);
    send(8'hAA);
    chk("t3r_pcclr", 32'(pc_clear), 32'd1);
    run_to_done("t3r");

    // 4: stalls with start pulses mid-frame
    w = wr_cnt;
    pulse_start();
    send(8'h04);
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 5; s++) begin
        start = (s == 2);
        tick();
        chk("t4_stall_ready", 32'(byte_ready), 32'd1);
        chk("t4_stall_we", 32'(mem_we), 32'd0);
      end
      start = 1'b0;
      case (k)
        0: send_data("t4", 8'h5A, 5'd0);
        1: send_data("t4", 8'hA5, 5'd1);
        2: send_data("t4", 8'h0F, 5'd2);
        default: send_data("t4", 8'hF0, 5'd3);
      endcase
    end
    chk("t4_busy", 32'(busy), 32'd1);
    send(8'hFE);
    chk("t4_pcclr", 32'(pc_clear), 32'd1);
    run_to_done("t4");
    chk("t4_nwr", 32'(wr_cnt - w), 32'd4);
    chk("t4_mem_word", {tbmem[0], tbmem[1], tbmem[2], tbmem[3]}, 32'h5AA50FF0);

    // 5: reset mid-load and mid-run
    pulse_start();
    send(8'h08);
    send_data("t5", 8'h77, 5'd0);
    send_data("t5", 8'h66, 5'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset_outputs("t5_load");
    chk("t5_mem_kept", 32'(tbmem[1]), 32'h66);
    pulse_start();
    send(8'h04);
    send_data("t5b", 8'h01, 5'd0);
    send_data("t5b", 8'h02, 5'd1);
    send_data("t5b", 8'h03, 5'd2);
    send_data("t5b", 8'h04, 5'd3);
    send(8'h0A);
    tick(); tick(); tick();
    chk("t5_running", 32'(cpu_run), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset_outputs("t5_run");
    tick();
    chk("t5_idle_run", 32'(cpu_run), 32'd0);

    // 6: full memory
    w = wr_cnt;
    cr = wr0_cnt;
    pulse_start();
    send(8'h20);
    for (int k = 0; k < 32; k++) send_data("t6", 8'(k), 5'(k));
    send(8'hF0);
    chk("t6_pcclr", 32'(pc_clear), 32'd1);
    run_to_done("t6");
    chk("t6_nwr", 32'(wr_cnt - w), 32'd32);
    chk("t6_addr0_once", 32'(wr0_cnt - cr), 32'd1);
    chk("t6_mem31", 32'(tbmem[31]), 32'h1F);
    chk("t6_mem0", 32'(tbmem[0]), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
